// File: rtl/iir_coef_loader.sv
// Coefficient loader for the biquad cascade: streams words into a shadow bank
// and commits the whole bank to the active `coefs` bus on a sample boundary.
module iir_coef_loader #(
  parameter int CASCADE_LEVEL = 10,
  parameter int CWIDTH        = 24
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              block_en,
  input  logic                              cfg_start,
  input  logic                              cfg_vld,
  output logic                              cfg_rdy,
  input  logic [CWIDTH-1:0]                 cfg_data,
  input  logic                              din_vld,
  output logic [CASCADE_LEVEL*5*CWIDTH-1:0] coefs,
  output logic                              busy,
  output logic                              load_done
);

  localparam int NWORDS = CASCADE_LEVEL * 5;
  localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WCW-1:0] LAST = WCW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PEND
  } state_t;

  state_t            r_state;
  logic [WCW-1:0]    r_wcnt;
  logic              r_rdy;
  logic              r_busy;
  logic              r_done;
  logic [CWIDTH-1:0] r_shadow [NWORDS];
  logic [CWIDTH-1:0] r_active [NWORDS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int unsigned i = 0; i < NWORDS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (!block_en) begin
        // The cascade is being cleared, so a pending bank needs no boundary.
        if (r_state == S_PEND) begin
          r_active <= r_shadow;
          r_done   <= 1'b1;
        end
        r_state <= S_IDLE;
        r_wcnt  <= '0;
        r_rdy   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cfg_start) begin
              r_state <= S_LOAD;
              r_wcnt  <= '0;
              r_rdy   <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            if (cfg_start) begin
              r_wcnt <= '0;
            end else if (cfg_vld && r_rdy) begin
              r_shadow[r_wcnt] <= cfg_data;
              if (r_wcnt == LAST) begin
                r_state <= S_PEND;
                r_wcnt  <= '0;
                r_rdy   <= 1'b0;
              end else begin
                r_wcnt <= r_wcnt + 1'b1;
              end
            end
          end
          S_PEND: begin
            if (din_vld) begin
              r_active <= r_shadow;
              r_done   <= 1'b1;
            end
            // A restart wins the next state even when it coincides with a commit.
            if (cfg_start) begin
              r_state <= S_LOAD;
              r_wcnt  <= '0;
              r_rdy   <= 1'b1;
            end else if (din_vld) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NWORDS; g++) begin : g_coefs
    assign coefs[g*CWIDTH +: CWIDTH] = r_active[g];
  end

  assign cfg_rdy   = r_rdy;
  assign busy      = r_busy;
  assign load_done = r_done;

endmodule

// File: tb/tb_iir_coef_loader.sv
// Self-checking bench for iir_coef_loader: randomized word streams checked
// against a transaction-level model of the shadow and active banks.
module tb_iir_coef_loader;

  localparam int CL = 10;
  localparam int CW = 24;
  localparam int NW = CL * 5;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               block_en = 1'b1;
  logic               cfg_start = 1'b0;
  logic               cfg_vld = 1'b0;
  logic               cfg_rdy;
  logic [CW-1:0]      cfg_data = '0;
  logic               din_vld = 1'b0;
  logic [NW*CW-1:0]   coefs;
  logic               busy;
  logic               load_done;

  int n_vec = 0;
  int n_err = 0;

  logic [CW-1:0] exp_bank  [NW];
  logic [CW-1:0] pend_bank [NW];

  iir_coef_loader #(.CASCADE_LEVEL(CL), .CWIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .block_en(block_en), .cfg_start(cfg_start),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_data(cfg_data),
    .din_vld(din_vld), .coefs(coefs), .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NW; i++) chk(tag, 64'(coefs[i*CW +: CW]), 64'(exp_bank[i]));
  endtask

  task automatic do_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("start_rdy", 64'(cfg_rdy), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
  endtask

  // Sends n words base+k; every LOAD cycle must show cfg_rdy high.
  task automatic send_words(input logic [CW-1:0] base, input int n, input bit gaps,
                            input bit din_on_last);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      while (gaps && $urandom_range(1) == 0 && guard < 1000) begin
        chk("rdy_gap", 64'(cfg_rdy), 64'd1);
        cfg_vld  = 1'b0;
        cfg_data = CW'($urandom);
        tick();
        guard++;
      end
      chk("rdy_load", 64'(cfg_rdy), 64'd1);
      cfg_vld  = 1'b1;
      cfg_data = base + CW'(k);
      if (din_on_last && k == n - 1) din_vld = 1'b1;
      tick();
      if (k < NW) pend_bank[k] = base + CW'(k);
    end
    cfg_vld = 1'b0;
    din_vld = 1'b0;
  endtask

  task automatic commit();
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    chk("commit_done", 64'(load_done), 64'd1);
    chk("commit_busy", 64'(busy), 64'd0);
    exp_bank = pend_bank;
    check_bank("commit_bank");
    tick();
    chk("done_once", 64'(load_done), 64'd0);
  endtask

  task automatic after_full_load(input string tag);
    chk({tag, "_rdy_low"}, 64'(cfg_rdy), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_no_done"}, 64'(load_done), 64'd0);
    check_bank({tag, "_old_bank"});
  endtask

  initial begin
    logic [CW-1:0] b;
    for (int i = 0; i < NW; i++) begin
      exp_bank[i]  = '0;
      pend_bank[i] = '0;
    end

    // Reset
    repeat (3) tick();
    chk("rst_rdy", 64'(cfg_rdy), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    check_bank("rst_bank");
    rstn = 1'b1;
    tick();

    // Basic load, data k+1, commit 5 cycles later
    do_start();
    send_words(24'd1, NW, 1'b0, 1'b0);
    after_full_load("basic");
    repeat (5) begin
      tick();
      chk("basic_wait_done", 64'(load_done), 64'd0);
    end
    check_bank("basic_wait_bank");
    commit();
    chk("basic_w0", 64'(coefs[CW-1:0]), 64'd1);
    chk("basic_w49", 64'(coefs[NW*CW-1 -: CW]), 64'd50);

    // Backpressure; din_vld on the final transfer must not commit
    do_start();
    send_words(24'hA00000, NW, 1'b1, 1'b1);
    after_full_load("bp");
    cfg_vld = 1'b1;
    cfg_data = 24'hDEAD00;
    tick();
    cfg_vld = 1'b0;
    chk("bp_no_overflow_rdy", 64'(cfg_rdy), 64'd0);
    commit();

    // Pending hold for 200 cycles
    do_start();
    b = CW'($urandom) & 24'hFFFF00;
    send_words(b, NW, 1'b1, 1'b0);
    after_full_load("hold");
    for (int c = 0; c < 200; c++) begin
      tick();
      if (busy !== 1'b1 || load_done !== 1'b0 || coefs[CW-1:0] !== exp_bank[0]) begin
        chk("hold_busy", 64'(busy), 64'd1);
        chk("hold_done", 64'(load_done), 64'd0);
        chk("hold_w0", 64'(coefs[CW-1:0]), 64'(exp_bank[0]));
      end
    end
    chk("hold_end_busy", 64'(busy), 64'd1);
    check_bank("hold_end_bank");
    commit();

    // Restart mid-load; the word offered with the restart is discarded
    do_start();
    send_words(24'h300000, 20, 1'b0, 1'b0);
    cfg_start = 1'b1;
    cfg_vld   = 1'b1;
    cfg_data  = 24'hBAD000;
    tick();
    cfg_start = 1'b0;
    cfg_vld   = 1'b0;
    chk("restart_rdy", 64'(cfg_rdy), 64'd1);
    send_words(24'h000100, NW, 1'b1, 1'b0);
    after_full_load("restart");
    commit();

    // cfg_start alone in PEND drops the pending bank
    do_start();
    send_words(24'h440000, NW, 1'b0, 1'b0);
    do_start();
    send_words(24'h450000 + CW'($urandom_range(255)), NW, 1'b1, 1'b0);
    commit();

    // cfg_start together with din_vld in PEND: commit then reload
    do_start();
    send_words(24'h660000, NW, 1'b0, 1'b0);
    cfg_start = 1'b1;
    din_vld   = 1'b1;
    tick();
    cfg_start = 1'b0;
    din_vld   = 1'b0;
    chk("sd_done", 64'(load_done), 64'd1);
    chk("sd_busy", 64'(busy), 64'd1);
    chk("sd_rdy", 64'(cfg_rdy), 64'd1);
    exp_bank = pend_bank;
    check_bank("sd_bank");
    send_words(24'h670000, NW, 1'b1, 1'b0);
    commit();

    // block_en drop mid-LOAD
    do_start();
    send_words(24'h555000, 30, 1'b0, 1'b0);
    block_en = 1'b0;
    tick();
    chk("dis_rdy", 64'(cfg_rdy), 64'd0);
    chk("dis_busy", 64'(busy), 64'd0);
    chk("dis_done", 64'(load_done), 64'd0);
    check_bank("dis_keep_bank");
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("dis_start_ignored", 64'(busy), 64'd0);
    block_en = 1'b1;
    tick();
    chk("reen_busy", 64'(busy), 64'd0);

    // block_en drop in PEND: immediate commit
    do_start();
    send_words(24'h770000, NW, 1'b1, 1'b0);
    block_en = 1'b0;
    tick();
    chk("dis_pend_done", 64'(load_done), 64'd1);
    chk("dis_pend_busy", 64'(busy), 64'd0);
    exp_bank = pend_bank;
    check_bank("dis_pend_bank");
    tick();
    chk("dis_pend_done_once", 64'(load_done), 64'd0);
    block_en = 1'b1;
    tick();

    // Async reset while in PEND
    do_start();
    send_words(24'h880000, NW, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < NW; i++) exp_bank[i] = '0;
    check_bank("arst_bank");
    chk("arst_busy", 64'(busy), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    chk("arst_no_commit", 64'(load_done), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);
    check_bank("arst_bank_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
